// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Purpose  : Shared widths, table depth and FSM state encoding for the
//            score tracker block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_W     = 7;
    localparam int ID_W        = 3;
    localparam int NUM_PLAYERS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        COMPARE = 3'd2,
        RESPOND = 3'd3,
        CLEAR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/score_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : score_tracker_if
// Purpose  : Request/response bundle between the score-checking initiator
//            and the score tracker.
// Signals  : score_req, score_in, intPlayID_in, isGuest_in, clear_scores
//              - initiator -> tracker
//            valid, personalwin, globalwin, global_score, global_id,
//            global_isGuest, busy
//              - tracker -> initiator
// Modports : master (initiator side), slave (tracker side)
// Revision : 1.0 - initial release
// ============================================================================
interface score_tracker_if;
    import score_pkg::*;

    logic               score_req;
    logic [SCORE_W-1:0] score_in;
    logic [ID_W-1:0]    intPlayID_in;
    logic               isGuest_in;
    logic               clear_scores;
    logic               valid;
    logic               personalwin;
    logic               globalwin;
    logic [SCORE_W-1:0] global_score;
    logic [ID_W-1:0]    global_id;
    logic               global_isGuest;
    logic               busy;

    modport master (
        output score_req, score_in, intPlayID_in, isGuest_in, clear_scores,
        input  valid, personalwin, globalwin, global_score, global_id,
               global_isGuest, busy
    );

    modport slave (
        input  score_req, score_in, intPlayID_in, isGuest_in, clear_scores,
        output valid, personalwin, globalwin, global_score, global_id,
               global_isGuest, busy
    );

endinterface
`default_nettype wire

// File: rtl/score_ram.sv
`default_nettype none
// ============================================================================
// Module   : score_ram
// Purpose  : 8 x 7-bit personal-best table. One registered read port, one
//            write port, all entries cleared by asynchronous reset.
// Ports    : clk                - clock
//            rst                - asynchronous reset, active-low
//            rd_en/rd_addr      - read request; rd_data valid next cycle
//            rd_data            - registered read data
//            we/wr_addr/wr_data - write port
// Revision : 1.0 - initial release
// ============================================================================
module score_ram
    import score_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               rd_en,
    input  wire logic [ID_W-1:0]    rd_addr,
    output logic      [SCORE_W-1:0] rd_data,
    input  wire logic               we,
    input  wire logic [ID_W-1:0]    wr_addr,
    input  wire logic [SCORE_W-1:0] wr_data
);

    logic [SCORE_W-1:0] mem_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] mem_d [NUM_PLAYERS];
    logic [SCORE_W-1:0] rd_data_q;
    logic [SCORE_W-1:0] rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (we) begin
            mem_d[wr_addr] = wr_data;
        end
        // Read returns the pre-write contents when both ports hit one entry.
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module   : score_tracker
// Purpose  : Checks submitted scores against each player's personal best and
//            the global best, updates the records and reports wins. Supports
//            a sequenced clear of all records.
// Ports    : clk - clock, rising edge
//            rst - asynchronous reset, active-low
//            bus - score_tracker_if.slave (request / response / status)
// Revision : 1.0 - initial release
// ============================================================================
module score_tracker
    import score_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    score_tracker_if.slave bus
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PLAYERS - 1);

    state_t             state_q,  state_d;
    logic [SCORE_W-1:0] score_q,  score_d;
    logic [ID_W-1:0]    id_q,     id_d;
    logic               guest_q,  guest_d;
    logic               pwin_q,   pwin_d;
    logic               gwin_q,   gwin_d;
    logic               valid_q,  valid_d;
    logic [SCORE_W-1:0] gscore_q, gscore_d;
    logic [ID_W-1:0]    gid_q,    gid_d;
    logic               gguest_q, gguest_d;
    logic [ID_W-1:0]    cnt_q,    cnt_d;
    logic               pend_q,   pend_d;

    logic               ram_rd_en;
    logic [SCORE_W-1:0] ram_rd_data;
    logic               ram_we;
    logic [ID_W-1:0]    ram_wr_addr;
    logic [SCORE_W-1:0] ram_wr_data;
    logic               w_pwin;
    logic               w_gwin;
    logic               go_clear;

    score_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (ram_rd_en),
        .rd_addr (id_q),
        .rd_data (ram_rd_data),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    // The RAM's registered read port holds the personal best fetched in READ.
    // Guests never fetch, so their stale read data is masked here.
    assign w_pwin = !guest_q && (score_q > ram_rd_data);
    assign w_gwin = score_q > gscore_q;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        id_d        = id_q;
        guest_d     = guest_q;
        pwin_d      = pwin_q;
        gwin_d      = gwin_q;
        gscore_d    = gscore_q;
        gid_d       = gid_q;
        gguest_d    = gguest_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        ram_rd_en   = 1'b0;
        ram_we      = 1'b0;
        ram_wr_addr = id_q;
        ram_wr_data = score_q;
        go_clear    = 1'b0;

        // valid is registered off RESPOND so it lands one edge after the
        // records update; the win flags are held through it, then dropped.
        valid_d = (state_q == RESPOND);
        if (valid_q) begin
            pwin_d = 1'b0;
            gwin_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.score_req) begin
                    score_d = bus.score_in;
                    id_d    = bus.intPlayID_in;
                    guest_d = bus.isGuest_in;
                    state_d = READ;
                end else if (bus.clear_scores || pend_q) begin
                    go_clear = 1'b1;
                end
            end
            READ: begin
                ram_rd_en = !guest_q;
                state_d   = COMPARE;
            end
            COMPARE: begin
                pwin_d = w_pwin;
                gwin_d = w_gwin;
                ram_we = w_pwin;
                if (w_gwin) begin
                    gscore_d = score_q;
                    gid_d    = id_q;
                    gguest_d = guest_q;
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (pend_q || bus.clear_scores) begin
                    go_clear = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                ram_we      = 1'b1;
                ram_wr_addr = cnt_q;
                ram_wr_data = '0;
                if (cnt_q == '0) begin
                    gscore_d = '0;
                    gid_d    = '0;
                    gguest_d = 1'b0;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ID) begin
                    if (pend_q || bus.clear_scores) begin
                        go_clear = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear that cannot start now is remembered until the current
        // operation finishes; starting a clear consumes it.
        if (bus.clear_scores && ((state_q != IDLE) || bus.score_req)) begin
            pend_d = 1'b1;
        end
        if (go_clear) begin
            state_d = CLEAR;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            score_q  <= '0;
            id_q     <= '0;
            guest_q  <= 1'b0;
            pwin_q   <= 1'b0;
            gwin_q   <= 1'b0;
            valid_q  <= 1'b0;
            gscore_q <= '0;
            gid_q    <= '0;
            gguest_q <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            id_q     <= id_d;
            guest_q  <= guest_d;
            pwin_q   <= pwin_d;
            gwin_q   <= gwin_d;
            valid_q  <= valid_d;
            gscore_q <= gscore_d;
            gid_q    <= gid_d;
            gguest_q <= gguest_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.valid          = valid_q;
    assign bus.personalwin    = pwin_q;
    assign bus.globalwin      = gwin_q;
    assign bus.global_score   = gscore_q;
    assign bus.global_id      = gid_q;
    assign bus.global_isGuest = gguest_q;
    assign bus.busy           = (state_q != IDLE);

endmodule
`default_nettype wire
